// File: rtl/sar_ctrl_n_if.sv
// sar_ctrl_n_if: handshake and analog-control bundle for the SAR controller.
// Ports: START/CONT/VCOMP/DREADY requests in; SARRST/SAMPLE/OUTEN/TRIAL to the
// DAC and bit FSMs; DOUT/DVALID/BUSY/OVR to the digital readout.
interface sar_ctrl_n_if #(
  parameter int NBITS = 4
);
  logic             START;
  logic             CONT;
  logic             VCOMP;
  logic             SARRST;
  logic             SAMPLE;
  logic [NBITS-1:0] OUTEN;
  logic [NBITS-1:0] TRIAL;
  logic [NBITS-1:0] DOUT;
  logic             DVALID;
  logic             DREADY;
  logic             BUSY;
  logic             OVR;

  // master: the controller itself
  modport master (
    input  START, CONT, VCOMP, DREADY,
    output SARRST, SAMPLE, OUTEN, TRIAL, DOUT, DVALID, BUSY, OVR
  );

  // slave: the analog front end / readout side
  modport slave (
    output START, CONT, VCOMP, DREADY,
    input  SARRST, SAMPLE, OUTEN, TRIAL, DOUT, DVALID, BUSY, OVR
  );
endinterface

// File: rtl/sar_ctrl_n.sv
// sar_ctrl_n: NBITS successive-approximation controller with a SAMPLE_CYCLES
//   sample window, single-shot/continuous modes, valid/ready result and sticky overrun.
// Ports: CLK, RESET_N (sync, active low); bus (master modport) carries START/CONT/
//   VCOMP/DREADY in and SARRST/SAMPLE/OUTEN/TRIAL/DOUT/DVALID/BUSY/OVR out.
module sar_ctrl_n #(
  parameter int NBITS         = 4,
  parameter int SAMPLE_CYCLES = 1
) (
  input logic          CLK,
  input logic          RESET_N,
  sar_ctrl_n_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONV,
    ST_LOAD
  } state_t;

  localparam logic [NBITS-1:0] MSB_BIT   = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [3:0]       SAMP_LAST = 4'(SAMPLE_CYCLES - 1);

  state_t           state;
  logic             arm;       // request seen in IDLE; sample phase opens on the following edge
  logic [3:0]       samp_cnt;
  logic             sarrst_q;
  logic             busy_q;
  logic             dvalid_q;
  logic             ovr_q;
  logic [NBITS-1:0] outen_q;
  logic [NBITS-1:0] trial_q;
  logic [NBITS-1:0] dout_q;

  // Code after this trial: the trial bit (the one set in outen_q) survives only
  // when the comparator says the input is at or above the trial level.
  logic [NBITS-1:0] decided;
  assign decided = bus.VCOMP ? trial_q : (trial_q & ~outen_q);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      arm      <= 1'b0;
      samp_cnt <= '0;
      sarrst_q <= 1'b0;
      busy_q   <= 1'b0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      outen_q  <= '0;
      trial_q  <= '0;
      dout_q   <= '0;
    end else begin
      // Consumer handshake; a LOAD on the same edge overrides this below.
      if (dvalid_q && bus.DREADY) begin
        dvalid_q <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (arm) begin
            arm      <= 1'b0;
            state    <= ST_SAMPLE;
            sarrst_q <= 1'b1;
            busy_q   <= 1'b1;
            samp_cnt <= '0;
          end else if (bus.START || bus.CONT) begin
            arm <= 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (samp_cnt == SAMP_LAST) begin
            state    <= ST_CONV;
            sarrst_q <= 1'b0;
            outen_q  <= MSB_BIT;
            trial_q  <= MSB_BIT;
          end else begin
            samp_cnt <= samp_cnt + 4'd1;
          end
        end

        ST_CONV: begin
          // The one-hot enable doubles as the bit index: bit 0 set means last trial.
          if (outen_q[0]) begin
            state   <= ST_LOAD;
            outen_q <= '0;
            trial_q <= decided;
          end else begin
            outen_q <= outen_q >> 1;
            trial_q <= decided | (outen_q >> 1);
          end
        end

        ST_LOAD: begin
          if (!dvalid_q || bus.DREADY) begin
            dout_q   <= trial_q;
            dvalid_q <= 1'b1;
          end else begin
            ovr_q <= 1'b1;
          end
          trial_q <= '0;
          if (bus.CONT) begin
            state    <= ST_SAMPLE;
            sarrst_q <= 1'b1;
            samp_cnt <= '0;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SARRST = sarrst_q;
  assign bus.SAMPLE = sarrst_q;
  assign bus.OUTEN  = outen_q;
  assign bus.TRIAL  = trial_q;
  assign bus.DOUT   = dout_q;
  assign bus.DVALID = dvalid_q;
  assign bus.BUSY   = busy_q;
  assign bus.OVR    = ovr_q;

endmodule

// File: tb/tb_sar_ctrl_n.sv
// tb_sar_ctrl_n: scoreboard bench for sar_ctrl_n with an ideal-comparator input model.
// Two instances: NBITS=4/SAMPLE_CYCLES=2 and NBITS=8/SAMPLE_CYCLES=1.
// Expected results are the input level in LSBs, expected arrival cycles come from timing rules.
module tb_sar_ctrl_n;

  localparam int N4 = 4;
  localparam int S4 = 2;
  localparam int P4 = S4 + N4 + 1;
  localparam int N8 = 8;
  localparam int S8 = 1;

  typedef struct {
    int code;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   vin4 = 0;      // analog input of the 4-bit converter, in LSBs
  int   vin8_t = 0;    // analog input of the 8-bit converter, in tenths of an LSB

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  logic prev_v4 = 1'b0, prev_v8 = 1'b0;
  logic [N4-1:0] prev_dout4 = '0;
  logic [N8-1:0] prev_dout8 = '0;

  sar_ctrl_n_if #(.NBITS(N4)) b4 ();
  sar_ctrl_n_if #(.NBITS(N8)) b8 ();

  sar_ctrl_n #(.NBITS(N4), .SAMPLE_CYCLES(S4)) u4 (.CLK(clk), .RESET_N(rst_n), .bus(b4));
  sar_ctrl_n #(.NBITS(N8), .SAMPLE_CYCLES(S8)) u8 (.CLK(clk), .RESET_N(rst_n), .bus(b8));

  // Ideal comparator: keep the trial bit when the input is at or above the DAC level.
  assign b4.VCOMP = (int'(b4.TRIAL) <= vin4);
  assign b8.VCOMP = (int'(b8.TRIAL) * 10 <= vin8_t);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance to just after the next falling edge; cyc then names the edge just passed.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  // Result monitors: a new result is on DOUT when DVALID rises, or stays high
  // after the previous one was accepted on the edge just passed.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v4 = 1'b0;
    end else begin
      if (b4.DVALID && (!prev_v4 || b4.DREADY)) begin
        if (q4.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result4: actual=%0d required=none (cycle %0d)", b4.DOUT, cyc);
        end else begin
          e4 = q4.pop_front();
          check("dout4", b4.DOUT, e4.code);
          check("latency4", cyc, e4.due);
        end
      end else if (prev_v4 && b4.DVALID) begin
        check("dout4_hold", b4.DOUT, prev_dout4);
      end
      prev_v4    = b4.DVALID;
      prev_dout4 = b4.DOUT;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v8 = 1'b0;
    end else begin
      if (b8.DVALID && (!prev_v8 || b8.DREADY)) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result8: actual=%0d required=none (cycle %0d)", b8.DOUT, cyc);
        end else begin
          e8 = q8.pop_front();
          check("dout8", b8.DOUT, e8.code);
          check("latency8", cyc, e8.due);
        end
      end else if (prev_v8 && b8.DVALID) begin
        check("dout8_hold", b8.DOUT, prev_dout8);
      end
      prev_v8    = b8.DVALID;
      prev_dout8 = b8.DOUT;
    end
  end

  // Single-shot conversion on the 4-bit instance; optionally checks every cycle of
  // the sample/trial/load sequence, then holds the result for 'hold' cycles.
  task automatic single4(input int v, input bit trace, input int hold);
    int t, i, bitv, esr, eoe, etr;
    vin4 = v;
    b4.DREADY = 1'b0;
    b4.START  = 1'b1;
    t = cyc + 1;
    q4.push_back('{v, t + S4 + N4 + 2});
    step(1);
    b4.START = 1'b0;
    for (int k = 1; k <= S4 + N4 + 1; k++) begin
      step(1);
      if (trace) begin
        if (k <= S4) begin
          esr = 1; eoe = 0; etr = 0;
        end else if (k <= S4 + N4) begin
          i    = k - S4 - 1;
          bitv = 1 << (N4 - 1 - i);
          esr  = 0;
          eoe  = bitv;
          etr  = ((v >> (N4 - i)) << (N4 - i)) | bitv;
        end else begin
          esr = 0; eoe = 0; etr = v;
        end
        check("trace_sarrst", b4.SARRST, esr);
        check("trace_sample", b4.SAMPLE, esr);
        check("trace_outen", b4.OUTEN, eoe);
        check("trace_trial", b4.TRIAL, etr);
        check("trace_busy", b4.BUSY, 1);
      end
    end
    step(1);
    check("single_busy_after", b4.BUSY, 0);
    check("single_dvalid", b4.DVALID, 1);
    step(hold);
    b4.DREADY = 1'b1;
    step(1);
    b4.DREADY = 1'b0;
    check("single_dvalid_cleared", b4.DVALID, 0);
    check("single_sb_empty", q4.size(), 0);
  endtask

  // Continuous run of vins.size() (>=2) conversions with DREADY held high.
  task automatic cont4(input int vins[$]);
    int m, t, sr;
    m  = vins.size();
    sr = 0;
    b4.DREADY = 1'b1;
    vin4 = vins[0];
    b4.CONT = 1'b1;
    t = cyc + 1;
    for (int j = 0; j < m; j++) q4.push_back('{vins[j], t + S4 + N4 + 2 + j * P4});
    step(1);
    for (int j = 1; j < m; j++) begin
      while (cyc < t + 1 + j * P4) begin
        step(1);
        sr += int'(b4.SARRST);
      end
      vin4 = vins[j];
      if (j == m - 1) b4.CONT = 1'b0;
    end
    while (cyc < t + S4 + N4 + 3 + (m - 1) * P4) begin
      step(1);
      sr += int'(b4.SARRST);
    end
    check("cont_sample_cycles", sr, m * S4);
    check("cont_busy_end", b4.BUSY, 0);
    check("cont_sb_empty", q4.size(), 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    int t, d0, nv;
    int vq[$];
    b4.START = 1'b0; b4.CONT = 1'b0; b4.DREADY = 1'b0;
    b8.START = 1'b0; b8.CONT = 1'b0; b8.DREADY = 1'b1;
    step(3);
    check("rst_sarrst", b4.SARRST, 0);
    check("rst_sample", b4.SAMPLE, 0);
    check("rst_outen", b4.OUTEN, 0);
    check("rst_trial", b4.TRIAL, 0);
    check("rst_dout", b4.DOUT, 0);
    check("rst_dvalid", b4.DVALID, 0);
    check("rst_busy", b4.BUSY, 0);
    check("rst_ovr", b4.OVR, 0);
    rst_n = 1'b1;
    step(2);

    // Directed: VCOMP pattern 1,0,1,1 (input level 11 LSB) with full trace.
    single4(11, 1'b1, 2);

    // Continuous, full scale then zero.
    vq = '{15, 0};
    cont4(vq);

    // Acceptance on the same edge as the next LOAD: no overrun, DOUT replaced.
    b4.DREADY = 1'b0;
    vin4 = 3;
    b4.CONT = 1'b1;
    t  = cyc + 1;
    d0 = t + S4 + N4 + 2;
    q4.push_back('{3, d0});
    q4.push_back('{9, d0 + P4});
    while (cyc < t + 1 + P4) step(1);
    vin4 = 9;
    b4.CONT = 1'b0;
    while (cyc < d0 + P4 - 1) step(1);
    b4.DREADY = 1'b1;
    step(1);
    b4.DREADY = 1'b0;
    check("same_edge_dvalid", b4.DVALID, 1);
    check("same_edge_dout", b4.DOUT, 9);
    check("same_edge_ovr", b4.OVR, 0);
    b4.DREADY = 1'b1;
    step(3);
    check("same_edge_sb_empty", q4.size(), 0);

    // Overrun: second result completes with the first still unconsumed.
    b4.DREADY = 1'b0;
    vin4 = 5;
    b4.CONT = 1'b1;
    t  = cyc + 1;
    d0 = t + S4 + N4 + 2;
    q4.push_back('{5, d0});
    while (cyc < t + 1 + P4) step(1);
    vin4 = 9;
    b4.CONT = 1'b0;
    while (cyc < d0 + P4 - 1) step(1);
    check("ovr_before", b4.OVR, 0);
    step(1);
    check("ovr_set", b4.OVR, 1);
    check("ovr_dout_kept", b4.DOUT, 5);
    check("ovr_dvalid", b4.DVALID, 1);
    b4.DREADY = 1'b1;
    step(1);
    b4.DREADY = 1'b0;
    step(1);
    check("ovr_dvalid_cleared", b4.DVALID, 0);
    check("ovr_sticky", b4.OVR, 1);
    check("ovr_sb_empty", q4.size(), 0);

    // Reset during the trial of bit 2 aborts with no result.
    vin4 = 6;
    b4.START = 1'b1;
    t = cyc + 1;
    step(1);
    b4.START = 1'b0;
    while (cyc < t + 1 + S4 + 1) step(1);
    check("abort_outen_bit2", b4.OUTEN, 4);
    rst_n = 1'b0;
    step(1);
    check("abort_sarrst", b4.SARRST, 0);
    check("abort_outen", b4.OUTEN, 0);
    check("abort_trial", b4.TRIAL, 0);
    check("abort_dout", b4.DOUT, 0);
    check("abort_dvalid", b4.DVALID, 0);
    check("abort_busy", b4.BUSY, 0);
    check("abort_ovr", b4.OVR, 0);
    rst_n = 1'b1;
    step(S4 + N4 + 3);
    check("abort_no_result", b4.DVALID, 0);
    single4(13, 1'b1, 0);

    // Randomised single-shot and continuous runs.
    repeat (10) begin
      single4(int'($urandom_range(0, 15)), 1'b0, int'($urandom_range(0, 3)));
    end
    repeat (3) begin
      vq = {};
      nv = int'($urandom_range(2, 4));
      repeat (nv) vq.push_back(int'($urandom_range(0, 15)));
      cont4(vq);
    end

    // 8-bit instance: input at 0.3 of full scale, then random levels.
    for (int r = 0; r < 5; r++) begin
      vin8_t = (r == 0) ? 768 : int'($urandom_range(0, 2559));
      b8.START = 1'b1;
      t = cyc + 1;
      q8.push_back('{vin8_t / 10, t + S8 + N8 + 2});
      step(1);
      b8.START = 1'b0;
      step(S8 + N8 + 3);
      check("conv8_sb_empty", q8.size(), 0);
      check("conv8_busy", b8.BUSY, 0);
    end

    check("final_q4", q4.size(), 0);
    check("final_q8", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
